// File: rtl/gemm_csr_pkg.sv
// Register map, STATUS bit positions and the descriptor record shared by the
// GEMM descriptor queue and its FIFO.
package gemm_csr_pkg;

    localparam logic [31:0] OFF_A_ADDR   = 32'h00;
    localparam logic [31:0] OFF_B_ADDR   = 32'h04;
    localparam logic [31:0] OFF_C_ADDR   = 32'h08;
    localparam logic [31:0] OFF_A_STRIDE = 32'h0C;
    localparam logic [31:0] OFF_B_STRIDE = 32'h10;
    localparam logic [31:0] OFF_CONTROL  = 32'h14;
    localparam logic [31:0] OFF_DIM      = 32'h18;
    localparam logic [31:0] OFF_DOORBELL = 32'h1C;
    localparam logic [31:0] OFF_STATUS   = 32'h20;
    localparam logic [31:0] OFF_DONE_CNT = 32'h24;
    localparam logic [31:0] OFF_CMD      = 32'h28;

    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_CNT_LSB = 8;

    typedef struct packed {
        logic [31:0] a_addr;
        logic [31:0] b_addr;
        logic [31:0] c_addr;
        logic [31:0] a_stride;
        logic [31:0] b_stride;
        logic [31:0] control;
        logic [31:0] dim;
    } gemm_desc_t;

endpackage

// File: rtl/desc_fifo.sv
// Show-ahead synchronous FIFO of GEMM descriptors with flush and a
// drop indication for pushes that find the queue full with no pop.
module desc_fifo
    import gemm_csr_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  gemm_desc_t    push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output gemm_desc_t    head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          drop_o,
    output logic [CW-1:0] count_o
);

    gemm_desc_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/gemm_desc_queue.sv
// Memory-mapped GEMM command front-end: staging registers, doorbell enqueue
// into a descriptor FIFO, status/done counter readback and flush.
module gemm_desc_queue
    import gemm_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DIM_W     = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             system_bus_en,
    input  logic             system_bus_rdwr,
    input  logic [31:0]      system_bus_addr,
    input  logic [31:0]      system_bus_wr_data,
    output logic [31:0]      system_bus_rd_data,
    output logic             desc_valid,
    input  logic             desc_ready,
    output logic [31:0]      tile_A_addr,
    output logic [31:0]      tile_B_addr,
    output logic [31:0]      tile_C_addr,
    output logic [31:0]      tile_A_stride,
    output logic [31:0]      tile_B_stride,
    output logic [DIM_W-1:0] msize,
    output logic [DIM_W-1:0] ksize,
    output logic [DIM_W-1:0] nsize,
    output logic             store,
    output logic             overwrite,
    input  logic             gemm_done
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    gemm_desc_t     stage_q, stage_d;
    gemm_desc_t     head;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic           ovf_q, ovf_d;
    logic [31:0]    rd_data_q, rd_data_d;
    logic [31:0]    offset;
    logic [31:0]    status;
    logic           wr_en, rd_en, push, flush, drop, empty, full;
    logic [CW-1:0]  count;
    logic           unused_head_bits;

    assign offset = system_bus_addr - BASE_ADDR;
    assign wr_en  = system_bus_en && system_bus_rdwr;
    assign rd_en  = system_bus_en && !system_bus_rdwr;
    assign push   = wr_en && (offset == OFF_DOORBELL);
    assign flush  = wr_en && (offset == OFF_CMD) && system_bus_wr_data[0];

    desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (stage_q),
        .pop_i       (desc_valid && desc_ready),
        .flush_i     (flush),
        .head_o      (head),
        .empty_o     (empty),
        .full_o      (full),
        .drop_o      (drop),
        .count_o     (count)
    );

    always_comb begin
        stage_d = stage_q;
        if (wr_en) begin
            case (offset)
                OFF_A_ADDR:   stage_d.a_addr   = system_bus_wr_data;
                OFF_B_ADDR:   stage_d.b_addr   = system_bus_wr_data;
                OFF_C_ADDR:   stage_d.c_addr   = system_bus_wr_data;
                OFF_A_STRIDE: stage_d.a_stride = system_bus_wr_data;
                OFF_B_STRIDE: stage_d.b_stride = system_bus_wr_data;
                OFF_CONTROL:  stage_d.control  = system_bus_wr_data;
                OFF_DIM:      stage_d.dim      = system_bus_wr_data;
                default:      stage_d          = stage_q;
            endcase
        end
    end

    // A dropped push outranks a same-cycle W1C of the overflow flag.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && (offset == OFF_STATUS) && system_bus_wr_data[ST_OVF]) ovf_d = 1'b0;
        if (drop) ovf_d = 1'b1;
    end

    always_comb begin
        done_cnt_d = done_cnt_q;
        if (gemm_done) done_cnt_d = done_cnt_q + CNT_W'(1);
    end

    always_comb begin
        status                      = '0;
        status[ST_EMPTY]            = empty;
        status[ST_FULL]             = full;
        status[ST_OVF]              = ovf_q;
        status[ST_CNT_LSB +: 8]     = 8'(count);
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            case (offset)
                OFF_A_ADDR:   rd_data_d = stage_q.a_addr;
                OFF_B_ADDR:   rd_data_d = stage_q.b_addr;
                OFF_C_ADDR:   rd_data_d = stage_q.c_addr;
                OFF_A_STRIDE: rd_data_d = stage_q.a_stride;
                OFF_B_STRIDE: rd_data_d = stage_q.b_stride;
                OFF_CONTROL:  rd_data_d = stage_q.control;
                OFF_DIM:      rd_data_d = stage_q.dim;
                OFF_STATUS:   rd_data_d = status;
                OFF_DONE_CNT: rd_data_d = 32'(done_cnt_q);
                default:      rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q    <= '0;
            done_cnt_q <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            stage_q    <= stage_d;
            done_cnt_q <= done_cnt_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign system_bus_rd_data = rd_data_q;
    assign desc_valid         = !empty;
    assign tile_A_addr        = head.a_addr;
    assign tile_B_addr        = head.b_addr;
    assign tile_C_addr        = head.c_addr;
    assign tile_A_stride      = head.a_stride;
    assign tile_B_stride      = head.b_stride;
    assign store              = head.control[0];
    assign overwrite          = head.control[1];
    assign msize              = head.dim[DIM_W-1:0];
    assign ksize              = head.dim[2*DIM_W-1:DIM_W];
    assign nsize              = head.dim[3*DIM_W-1:2*DIM_W];
    assign unused_head_bits   = ^(head.dim >> (3*DIM_W)) ^ (^head.control[31:2]);

endmodule

// File: tb/tb_gemm_desc_queue.sv
// Self-checking bench for gemm_desc_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_gemm_desc_queue;

    localparam logic [31:0] BASE  = 32'h9000_0000;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DIM_W = 5;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             bus_en, bus_rdwr;
    logic [31:0]      bus_addr, bus_wd, bus_rd;
    logic             desc_valid, desc_ready, gemm_done;
    logic [31:0]      a_addr, b_addr, c_addr, a_stride, b_stride;
    logic [DIM_W-1:0] msize, ksize, nsize;
    logic             store, overwrite;

    int errors = 0;
    int checks = 0;

    gemm_desc_queue #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .DIM_W     (DIM_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .system_bus_en      (bus_en),
        .system_bus_rdwr    (bus_rdwr),
        .system_bus_addr    (bus_addr),
        .system_bus_wr_data (bus_wd),
        .system_bus_rd_data (bus_rd),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .tile_A_addr        (a_addr),
        .tile_B_addr        (b_addr),
        .tile_C_addr        (c_addr),
        .tile_A_stride      (a_stride),
        .tile_B_stride      (b_stride),
        .msize              (msize),
        .ksize              (ksize),
        .nsize              (nsize),
        .store              (store),
        .overwrite          (overwrite),
        .gemm_done          (gemm_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: staging words, descriptor queue, flags.
    logic [31:0]  stg [7];
    logic [223:0] mq [$];
    logic         m_ovf;
    int unsigned  m_cnt;
    logic [31:0]  m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) stg[i] = '0;
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        m_rd  = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] off);
        int unsigned n;
        n = mq.size();
        if (off <= 32'h18 && off[1:0] == 2'b00) return stg[off / 4];
        if (off == 32'h20)
            return {16'h0, 8'(n), 5'h0, m_ovf, (n == DEPTH) ? 1'b1 : 1'b0, (n == 0) ? 1'b1 : 1'b0};
        if (off == 32'h24) return m_cnt;
        return '0;
    endfunction

    task automatic model_step(input logic en, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic rdy, input logic dn);
        logic [31:0] off;
        off = addr - BASE;
        if (en && !wr) m_rd = m_read(off);
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (en && wr) begin
            if (off <= 32'h18 && off[1:0] == 2'b00) stg[off / 4] = wd;
            else if (off == 32'h1C) begin
                if (mq.size() < DEPTH)
                    mq.push_back({stg[0], stg[1], stg[2], stg[3], stg[4], stg[5], stg[6]});
                else
                    m_ovf = 1'b1;
            end else if (off == 32'h20) begin
                if (wd[2]) m_ovf = 1'b0;
            end else if (off == 32'h28) begin
                if (wd[0]) mq.delete();
            end
        end
        if (dn) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    endtask

    function automatic logic [31:0] dut_field(input int i);
        case (i)
            0: return a_addr;
            1: return b_addr;
            2: return c_addr;
            3: return a_stride;
            4: return b_stride;
            5: return {30'h0, overwrite, store};
            default: return {17'h0, nsize, ksize, msize};
        endcase
    endfunction

    task automatic model_compare();
        logic [223:0] h;
        logic [31:0]  f;
        chk("model valid", {31'h0, desc_valid}, (mq.size() != 0) ? 32'h1 : 32'h0);
        chk("model rd_data", bus_rd, m_rd);
        if (mq.size() != 0) begin
            h = mq[0];
            for (int i = 0; i < 7; i++) begin
                f = h[32*(6-i) +: 32];
                if (i == 5) f = f & 32'h3;
                if (i == 6) f = f & 32'h7FFF;
                chk($sformatf("model head field %0d", i), dut_field(i), f);
            end
        end
    endtask

    // Called at a negedge: drive, let one posedge pass, return at the next negedge.
    task automatic step(input logic en, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic rdy, input logic dn);
        bus_en = en; bus_rdwr = wr; bus_addr = addr; bus_wd = wd;
        desc_ready = rdy; gemm_done = dn;
        model_step(en, wr, addr, wd, rdy, dn);
        @(negedge clk);
        bus_en = 1'b0; bus_rdwr = 1'b0; desc_ready = 1'b0; gemm_done = 1'b0;
        model_compare();
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        step(1'b1, 1'b1, BASE + off, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy, input logic dn);
        step(1'b0, 1'b0, BASE, 32'h0, rdy, dn);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
        step(1'b1, 1'b0, BASE + off, 32'h0, 1'b0, 1'b0);
        chk(name, bus_rd, exp);
    endtask

    typedef struct {
        logic        en;
        logic        wr;
        logic [31:0] off;
        logic [31:0] wd;
        logic        exp_valid;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic en, input logic w, input logic [31:0] off,
                                input logic [31:0] wd, input logic ev, input logic cr,
                                input logic [31:0] er);
        vec_t v;
        v.en = en; v.wr = w; v.off = off; v.wd = wd;
        v.exp_valid = ev; v.chk_rd = cr; v.exp_rd = er;
        return v;
    endfunction

    logic [31:0] fp_exp [4];
    int          popped;
    logic [31:0] r_off, r_wd;
    logic        r_wr, r_en;

    initial begin
        rst = 1'b1;
        bus_en = 1'b0; bus_rdwr = 1'b0; bus_addr = '0; bus_wd = '0;
        desc_ready = 1'b0; gemm_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset valid", {31'h0, desc_valid}, 32'h0);
        chk("reset rd_data", bus_rd, 32'h0);
        rst = 1'b0;

        tbl.push_back(mk(1, 1, 32'h00, 32'h0000_1000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h04, 32'h0000_2000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h08, 32'h0000_3000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0C, 32'd64, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h10, 32'd64, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h14, 32'h3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h18, 32'h0000_1483, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h20, 0, 0, 1, 32'h0000_0001));
        tbl.push_back(mk(1, 1, 32'h1C, 32'hDEAD_BEEF, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h20, 0, 1, 1, 32'h0000_0100));
        tbl.push_back(mk(1, 0, 32'h00, 0, 1, 1, 32'h0000_1000));
        tbl.push_back(mk(1, 0, 32'h18, 0, 1, 1, 32'h0000_1483));
        tbl.push_back(mk(1, 0, 32'h1C, 0, 1, 1, 32'h0));
        tbl.push_back(mk(1, 0, 32'h28, 0, 1, 1, 32'h0));
        tbl.push_back(mk(1, 1, 32'h24, 32'h3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h24, 0, 1, 1, 32'h0));
        tbl.push_back(mk(1, 0, 32'h30, 0, 1, 1, 32'h0));
        tbl.push_back(mk(1, 1, 32'h14, 32'hFFFF_FFFC, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h14, 0, 1, 1, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 0, 32'h00, 0, 1, 1, 32'hFFFF_FFFC));
        tbl.push_back(mk(1, 1, 32'h14, 32'h3, 1, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].wr, BASE + tbl[i].off, tbl[i].wd, 1'b0, 1'b0);
            chk($sformatf("table %0d valid", i), {31'h0, desc_valid}, {31'h0, tbl[i].exp_valid});
            if (tbl[i].chk_rd) chk($sformatf("table %0d rd_data", i), bus_rd, tbl[i].exp_rd);
        end

        chk("head A addr", a_addr, 32'h0000_1000);
        chk("head msize", 32'(msize), 32'd3);
        chk("head ksize", 32'(ksize), 32'd4);
        chk("head nsize", 32'(nsize), 32'd5);
        chk("head store/overwrite", {30'h0, overwrite, store}, 32'h3);
        idle(1'b1, 1'b0);
        chk("pop to empty", {31'h0, desc_valid}, 32'h0);

        // Overflow on the fifth doorbell with no consumer.
        for (int i = 0; i < 5; i++) begin
            wr(32'h00, 32'h5000 + 32'(i) * 32'h100);
            wr(32'h1C, 32'h0);
            if (i == 3) rd_chk("status full", 32'h20, 32'h0000_0402);
            if (i == 4) rd_chk("status overflow", 32'h20, 32'h0000_0406);
        end
        wr(32'h20, 32'h4);
        rd_chk("status ovf cleared", 32'h20, 32'h0000_0402);

        // Push while full with a simultaneous pop.
        wr(32'h00, 32'h0000_AAAA);
        step(1'b1, 1'b1, BASE + 32'h1C, 32'h0, 1'b1, 1'b0);
        rd_chk("full push+pop status", 32'h20, 32'h0000_0402);
        fp_exp[0] = 32'h5100; fp_exp[1] = 32'h5200; fp_exp[2] = 32'h5300; fp_exp[3] = 32'hAAAA;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("full drain head %0d", k), a_addr, fp_exp[k]);
            idle(1'b1, 1'b0);
        end
        chk("drained valid", {31'h0, desc_valid}, 32'h0);

        // Ordering with a toggling ready, then pointer wrap.
        for (int i = 0; i < 3; i++) begin
            wr(32'h00, 32'h7000 + 32'(i));
            wr(32'h1C, 32'h0);
        end
        popped = 0;
        for (int j = 0; j < 6; j++) begin
            if (j % 2 == 1) begin
                chk($sformatf("order head %0d", popped), a_addr, 32'h7000 + 32'(popped));
                popped++;
            end
            idle((j % 2 == 1) ? 1'b1 : 1'b0, 1'b0);
        end
        chk("order drained", {31'h0, desc_valid}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            wr(32'h00, 32'h8000 + 32'(i));
            wr(32'h1C, 32'h0);
            chk($sformatf("wrap head %0d", i), a_addr, 32'h8000 + 32'(i));
            idle(1'b1, 1'b0);
        end

        // Flush outranks a same-cycle pop.
        for (int i = 0; i < 3; i++) begin
            wr(32'h00, 32'h9000 + 32'(i));
            wr(32'h1C, 32'h0);
        end
        step(1'b1, 1'b1, BASE + 32'h28, 32'h1, 1'b1, 1'b0);
        chk("flush valid", {31'h0, desc_valid}, 32'h0);
        rd_chk("flush status", 32'h20, 32'h0000_0001);
        rd_chk("flush done_cnt", 32'h24, 32'h0);

        // Completion counter wraps at 2^CNT_W.
        repeat (3) idle(1'b0, 1'b1);
        rd_chk("done_cnt 3", 32'h24, 32'd3);
        idle(1'b0, 1'b1);
        rd_chk("done_cnt wrap", 32'h24, 32'd0);

        // Asynchronous reset while entries are pending.
        wr(32'h00, 32'h1234);
        wr(32'h1C, 32'h0);
        wr(32'h1C, 32'h0);
        idle(1'b0, 1'b1);
        rd_chk("pre-reset A", 32'h00, 32'h1234);
        #2 rst = 1'b1;
        #1;
        chk("async reset valid", {31'h0, desc_valid}, 32'h0);
        chk("async reset rd_data", bus_rd, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rd_chk("post-reset status", 32'h20, 32'h0000_0001);
        rd_chk("post-reset A", 32'h00, 32'h0);
        rd_chk("post-reset done_cnt", 32'h24, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r_off = 32'($urandom_range(0, 12)) * 32'h4;
            r_wr  = 1'($urandom_range(0, 1));
            r_en  = ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0;
            r_wd  = $urandom;
            if ($urandom_range(0, 9) < 3) begin
                r_off = 32'h1C;
                r_wr  = 1'b1;
            end
            if (r_off == 32'h28 && $urandom_range(0, 3) != 0) r_wd[0] = 1'b0;
            step(r_en, r_wr, BASE + r_off, r_wd,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
